// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a ps2c glitch filter,
// odd-parity and stop-bit checking, an inter-bit watchdog and a byte FIFO
// with a read handshake. Ticks are combinational one-cycle pulses raised in
// the CHECK cycle (or the watchdog abort cycle).
// Optional feature macro: PS2_RX_ERR_COUNT_EN adds an 8-bit saturating
// err_count output that counts error/overflow ticks.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rx_en,
    input  logic                          rd_en,
    output logic [7:0]                    dout,
    output logic                          dout_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_done_tick,
    output logic                          parity_err_tick,
    output logic                          frame_err_tick,
    output logic                          timeout_tick,
    output logic                          overflow_tick
`ifdef PS2_RX_ERR_COUNT_EN
    ,
    output logic [7:0]                    err_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    // The abort fires in the cycle where the incremented watchdog would
    // reach TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK
    } state_t;

    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic                  fall;

    state_t                state_q, state_d;
    logic [10:0]           bits_q, bits_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    // The start bit is guaranteed 0 by the IDLE entry condition; it is kept
    // in the shift register only so the frame lines up with its bit numbers.
    logic                  unused_start_bit;
    assign unused_start_bit = bits_q[0];

    // Glitch filter: shift ps2c in, switch the filtered clock only on a
    // unanimous window, and flag the 1->0 transition.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch
        // can be inferred on a path that leaves it unassigned.
        filt_d = {ps2c, filt_q[FILTER_LEN-1:1]};
        fclk_d = fclk_q;
        if (&filt_q) begin
            fclk_d = 1'b1;
        end else if (~|filt_q) begin
            fclk_d = 1'b0;
        end
        fall = fclk_q & ~fclk_d;
    end

    // FIFO status and pop qualification.
    always_comb begin
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        pop        = rd_en & ~empty;
        dout       = mem_q[rd_ptr_q];
        dout_valid = ~empty;
        fifo_count = count_q;
    end

    // Frame FSM: next state, shift register, bit counter, watchdog, ticks.
    always_comb begin
        state_d         = state_q;
        bits_d          = bits_q;
        cnt_d           = cnt_q;
        wd_d            = wd_q;
        push            = 1'b0;
        rx_done_tick    = 1'b0;
        parity_err_tick = 1'b0;
        frame_err_tick  = 1'b0;
        timeout_tick    = 1'b0;
        overflow_tick   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall && rx_en && !ps2d) begin
                    bits_d  = {ps2d, bits_q[10:1]};
                    cnt_d   = 4'd9;
                    wd_d    = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    bits_d = {ps2d, bits_q[10:1]};
                    wd_d   = '0;
                    if (cnt_q == 4'd0) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    timeout_tick = 1'b1;
                    wd_d         = '0;
                    state_d      = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!bits_q[10]) begin
                    frame_err_tick = 1'b1;
                end else if (!(^bits_q[9:1])) begin
                    parity_err_tick = 1'b1;
                end else if (full && !pop) begin
                    overflow_tick = 1'b1;
                end else begin
                    push         = 1'b1;
                    rx_done_tick = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of block evaluation order.
        if (reset) begin
            filt_q   <= '0;
            fclk_q   <= 1'b0;
            state_q  <= IDLE;
            bits_q   <= '0;
            cnt_q    <= '0;
            wd_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            filt_q   <= filt_d;
            fclk_q   <= fclk_d;
            state_q  <= state_d;
            bits_q   <= bits_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; an empty FIFO
        // (count = 0) makes its contents irrelevant.
        if (push) begin
            mem_q[wr_ptr_q] <= bits_q[8:1];
        end
    end

`ifdef PS2_RX_ERR_COUNT_EN
    logic [7:0] err_q, err_d;

    // Saturating count of cycles carrying any error or overflow tick.
    always_comb begin
        err_d = err_q;
        if ((parity_err_tick || frame_err_tick || timeout_tick || overflow_tick)
            && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: table-driven vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model of ps2_rx_fifo.
// Also exercises err_count when PS2_RX_ERR_COUNT_EN is defined.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int FIFO_DEPTH     = 4;
    localparam int CW             = $clog2(FIFO_DEPTH) + 1;
    localparam int HALF           = 20;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          ps2c  = 1'b1;
    logic          ps2d  = 1'b1;
    logic          rx_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [7:0]    dout;
    logic          dout_valid;
    logic [CW-1:0] fifo_count;
    logic          rx_done_tick;
    logic          parity_err_tick;
    logic          frame_err_tick;
    logic          timeout_tick;
    logic          overflow_tick;
`ifdef PS2_RX_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    ps2_rx_fifo #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2c           (ps2c),
        .ps2d           (ps2d),
        .rx_en          (rx_en),
        .rd_en          (rd_en),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .fifo_count     (fifo_count),
        .rx_done_tick   (rx_done_tick),
        .parity_err_tick(parity_err_tick),
        .frame_err_tick (frame_err_tick),
        .timeout_tick   (timeout_tick),
        .overflow_tick  (overflow_tick)
`ifdef PS2_RX_ERR_COUNT_EN
        ,
        .err_count      (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick monitor, sampled just after the falling edge.
    int n_done = 0, n_perr = 0, n_ferr = 0, n_to = 0, n_ovf = 0;
    int to_cyc = 0;
    always begin
        @(negedge clk);
        #1;
        if (rx_done_tick)    n_done++;
        if (parity_err_tick) n_perr++;
        if (frame_err_tick)  n_ferr++;
        if (overflow_tick)   n_ovf++;
        if (timeout_tick) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int s_done, s_perr, s_ferr, s_to, s_ovf;
    int fall_drive = 0;
    logic [7:0] model_q[$];

    typedef struct {
        logic [7:0] data;
        bit         par_ok;
        bit         stop;
        bit         exp_done;
        bit         exp_perr;
        bit         exp_ferr;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par_ok, input bit stop);
        logic p;
        p = par_ok ? ~^d : ^d;
        return {stop, p, d, 1'b0};
    endfunction

    task automatic snap();
        s_done = n_done; s_perr = n_perr; s_ferr = n_ferr; s_to = n_to; s_ovf = n_ovf;
    endtask

    task automatic check_ticks(input string name, input int ed, input int ep, input int ef,
                               input int et, input int eo);
        check({name, ".done"},  n_done - s_done, ed);
        check({name, ".perr"},  n_perr - s_perr, ep);
        check({name, ".ferr"},  n_ferr - s_ferr, ef);
        check({name, ".tmo"},   n_to - s_to,     et);
        check({name, ".ovf"},   n_ovf - s_ovf,   eo);
    endtask

    // Drive bits b[0..nbits-1]; data changes while ps2c is high.
    task automatic send_bits(input logic [10:0] b, input int nbits, input int drop_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_at) rx_en = 1'b0;
            ps2d = b[i];
            wait_cyc(HALF);
            ps2c = 1'b0;
            fall_drive = cyc;
            wait_cyc(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop);
        send_bits(make_frame(d, par_ok, stop), 11, -1);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, ".valid"}, dout_valid, 1'b1);
        check({name, ".dout"},  dout, exp);
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};

        // Reset state
        wait_cyc(3);
        check("rst.valid", dout_valid, 1'b0);
        check("rst.count", fifo_count, 0);
        check("rst.ticks", {rx_done_tick, parity_err_tick, frame_err_tick,
                            timeout_tick, overflow_tick}, 5'b0);
`ifdef PS2_RX_ERR_COUNT_EN
        check("rst.errcnt", err_count, 8'd0);
`endif
        reset = 1'b0;
        rx_en = 1'b1;
        wait_cyc(2 * FILTER_LEN);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].par_ok, vecs[i].stop);
            check_ticks($sformatf("vec%0d", i), int'(vecs[i].exp_done), int'(vecs[i].exp_perr),
                        int'(vecs[i].exp_ferr), 0, 0);
            check($sformatf("vec%0d.count", i), fifo_count, vecs[i].exp_cnt);
            if (vecs[i].exp_done) begin
                pop_check($sformatf("vec%0d.pop", i), vecs[i].data);
                check($sformatf("vec%0d.count_pop", i), fifo_count, 0);
            end
        end

        // Pop while empty is ignored
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
        check("empty_pop.count", fifo_count, 0);
        check("empty_pop.valid", dout_valid, 1'b0);

        // Watchdog: start + 4 bits, then ps2c held high
        snap();
        send_bits(make_frame(8'h3C, 1'b1, 1'b1), 5, -1);
        for (int k = 0; k < 2 * TIMEOUT_CYCLES && n_to == s_to; k++) wait_cyc(1);
        wait_cyc(2);
        check_ticks("tmo", 0, 0, 0, 1, 0);
        check("tmo.cycle", to_cyc, fall_drive + FILTER_LEN + TIMEOUT_CYCLES - 1);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1);
        check_ticks("after_tmo", 1, 0, 0, 0, 0);
        pop_check("after_tmo.pop", 8'h3C);

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
        check("fill.count", fifo_count, 4);
        snap();
        send_frame(8'h05, 1'b1, 1'b1);
        check_ticks("ovf", 0, 0, 0, 0, 1);
        check("ovf.count", fifo_count, 4);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("drain%0d", i), 8'(i));
        check("drain.count", fifo_count, 0);

        // Write with simultaneous pop while full
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
        snap();
        send_bits(make_frame(8'h55, 1'b1, 1'b1), 10, -1);
        ps2d = 1'b1;
        wait_cyc(HALF);
        ps2c = 1'b0;
        wait_cyc(FILTER_LEN + 1);
        rd_en = 1'b1;
        #1;
        check("wpop.done_tick", rx_done_tick, 1'b1);
        check("wpop.ovf_tick",  overflow_tick, 1'b0);
        check("wpop.head",      dout, 8'h01);
        wait_cyc(1);
        rd_en = 1'b0;
        check("wpop.count", fifo_count, 4);
        wait_cyc(HALF);
        ps2c = 1'b1;
        wait_cyc(HALF);
        check_ticks("wpop", 1, 0, 0, 0, 0);
        pop_check("wpop.d2", 8'h02);
        pop_check("wpop.d3", 8'h03);
        pop_check("wpop.d4", 8'h04);
        pop_check("wpop.d5", 8'h55);

        // Glitch shorter than the filter while idle
        snap();
        ps2c = 1'b0;
        wait_cyc(FILTER_LEN - 1);
        ps2c = 1'b1;
        wait_cyc(3 * HALF);
        check_ticks("glitch", 0, 0, 0, 0, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check_ticks("glitch_frame", 1, 0, 0, 0, 0);
        pop_check("glitch.pop", 8'h5A);

        // rx_en low for a whole frame, then dropped mid-frame
        snap();
        rx_en = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        check_ticks("rxen_off", 0, 0, 0, 0, 0);
        check("rxen_off.count", fifo_count, 0);
        rx_en = 1'b1;
        snap();
        send_bits(make_frame(8'h22, 1'b1, 1'b1), 11, 3);
        check_ticks("rxen_drop", 1, 0, 0, 0, 0);
        pop_check("rxen_drop.pop", 8'h22);
        rx_en = 1'b1;

        // Reset mid-frame with two bytes buffered
        send_frame(8'h10, 1'b1, 1'b1);
        send_frame(8'h20, 1'b1, 1'b1);
        check("pre_rst.count", fifo_count, 2);
        send_bits(make_frame(8'h99, 1'b1, 1'b1), 5, -1);
        reset = 1'b1;
        wait_cyc(2);
        check("mid_rst.count", fifo_count, 0);
        check("mid_rst.valid", dout_valid, 1'b0);
        reset = 1'b0;
        snap();
        send_frame(8'h7E, 1'b1, 1'b1);
        check_ticks("post_rst", 1, 0, 0, 0, 0);
        check("post_rst.count", fifo_count, 1);
        pop_check("post_rst.pop", 8'h7E);

`ifdef PS2_RX_ERR_COUNT_EN
        check("errcnt.zero", err_count, 8'd0);
        send_frame(8'h31, 1'b0, 1'b1);
        send_frame(8'h32, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        check("errcnt.three", err_count, 8'd3);
`endif

        // Randomized frames against a queue model
        model_q.delete();
        for (int it = 0; it < 30; it++) begin
            logic [7:0] d;
            int         r;
            int         npop;
            int         ed, ep, ef, eo;
            bit         stop, par_ok;
            d      = 8'($urandom);
            r      = int'($urandom_range(0, 9));
            stop   = (r != 0);
            par_ok = (r != 1) && (r != 2);
            ed = 0; ep = 0; ef = 0; eo = 0;
            if (!stop) ef = 1;
            else if (!par_ok) ep = 1;
            else if (model_q.size() == FIFO_DEPTH) eo = 1;
            else begin
                ed = 1;
                model_q.push_back(d);
            end
            snap();
            send_frame(d, par_ok, stop);
            check_ticks($sformatf("rnd%0d", it), ed, ep, ef, 0, eo);
            check($sformatf("rnd%0d.count", it), fifo_count, model_q.size());
            npop = int'($urandom_range(0, 2));
            for (int k = 0; k < npop; k++) begin
                if (model_q.size() > 0) pop_check($sformatf("rnd%0d.pop%0d", it, k), model_q.pop_front());
            end
        end
        while (model_q.size() > 0) pop_check("rnd.drain", model_q.pop_front());
        check("rnd.final_count", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver that succeeds the basic receiver. It adds a configurable clock glitch filter, odd-parity and stop-bit checking, and an inter-bit watchdog timeout. Good frames are buffered in a FIFO with a read handshake. It sits between the PS/2 pins (already synchronised) and the mouse packet decoder.

Parameters:
FILTER_LEN, 8, ps2c filter depth in clk samples (>=2)
TIMEOUT_CYCLES, 100000, clk cycles allowed between falling edges inside a frame before abort (>=2)
FIFO_DEPTH, 4, byte FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ps2c  in  1  PS/2 clock line (synchronised)
ps2d  in  1  PS/2 data line (synchronised)
rx_en  in  1  enables start-of-frame detection
rd_en  in  1  pop request; honoured only when dout_valid=1
dout  out  8  FIFO head byte; valid when dout_valid=1
dout_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
rx_done_tick  out  1  one-cycle pulse: good frame written to FIFO
parity_err_tick  out  1  one-cycle pulse: parity check failed
frame_err_tick  out  1  one-cycle pulse: stop bit = 0
timeout_tick  out  1  one-cycle pulse: frame aborted by watchdog
overflow_tick  out  1  one-cycle pulse: good frame dropped because FIFO full

Behaviour:
- Reset (synchronous, active-high): filter shift register = 0, filtered clock = 0, state = IDLE, bit counter = 0, watchdog = 0, FIFO pointers and count = 0. All ticks = 0, dout_valid = 0, fifo_count = 0.
- Filter:
  - ps2c shifts into a FILTER_LEN-bit register every clk.
  - Filtered clock goes to 1 when the register is all ones, to 0 when it is all zeros, otherwise holds.
  - fall = filtered_reg & ~filtered_next.
- Frame format: bits sampled on fall, LSB first: start(0), d0..d7, parity, stop(1). Shift register is 11 bits, right-shift in.
- FSM:
  - IDLE:
    - On fall & rx_en & ps2d==0: shift in the start bit, load bit counter = 9, clear watchdog, go to DATA.
    - fall with ps2d==1 is ignored.
    - rx_en is sampled only in IDLE.
  - DATA:
    - On each fall: shift in ps2d and clear the watchdog. If counter==0, go to CHECK; else decrement.
    - Without fall: watchdog increments. When it reaches TIMEOUT_CYCLES-1, pulse timeout_tick and go to IDLE with no write.
    - A fall in the same cycle as the limit wins: no timeout.
  - CHECK (exactly 1 cycle):
    - stop = b[10]. Parity ok = ^(b[9:1]) == 1.
    - If stop==0: frame_err_tick=1.
    - Else if parity fails: parity_err_tick=1.
    - Else write b[8:1] to the FIFO and pulse rx_done_tick; if the FIFO is full, pulse overflow_tick instead and discard the byte.
    - Both errors at once: only frame_err_tick.
    - Always return to IDLE.
- Latency: CHECK follows the stop-bit fall cycle. dout_valid/fifo_count update in the cycle after CHECK.
- FIFO:
  - dout is combinational from the head entry.
  - rd_en while empty is ignored.
  - Simultaneous write and pop: both occur and count is unchanged, including when full (no overflow in that case).
  - Pointers wrap modulo FIFO_DEPTH.
- rx_en deassertion mid-frame does not abort.
- Reset mid-frame: discard the partial frame; FIFO contents are lost.

Optional Feature:
PS2_RX_ERR_COUNT_EN:
- Defined: adds output err_count [7:0], reset to 0. It increments by 1 on any cycle where parity_err_tick, frame_err_tick, timeout_tick or overflow_tick is 1, and saturates at 255.
- Undefined: no port, no counter logic.

Test Plan:
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, parity 1, stop 1), rx_en=1 -> rx_done_tick once, dout=0xA5, dout_valid=1, fifo_count=1; rd_en -> fifo_count=0.
- Frame 0xA5 with parity 0 -> parity_err_tick once, fifo_count stays 0; repeat with stop 0 and parity 0 -> frame_err_tick only.
- TIMEOUT_CYCLES=200: send start plus 4 bits then hold ps2c high -> timeout_tick exactly 199 cycles after the last fall; then a full frame 0x3C is received correctly.
- FIFO_DEPTH=4: send 0x01..0x05 without reading -> fifo_count=4, overflow_tick on the 5th frame, pops return 0x01..0x04; write with simultaneous pop at full -> no overflow, count stays 4.
- ps2c glitch of FILTER_LEN-1 low cycles while idle -> no fall, no state change; rx_en=0 during start edge -> frame ignored, and rx_en dropped mid-frame -> frame still completes.
- Reset asserted after 5 bits with 2 bytes buffered -> fifo_count=0, dout_valid=0, next frame 0x7E received correctly; with PS2_RX_ERR_COUNT_EN defined, 3 errors -> err_count=3.
